fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the pipelined RV32I core, directly upstream of decode and the immediate sign-extender. Holds the PC, issues requests to the 2-way instruction cache, tolerates miss latency, applies branch/jump redirects from Execute, and drives the IF/ID pipeline register whose `InstrD[31:7]` feeds immediate generation in Decode.

## Interface
- `ADDRESS_WIDTH`, 32, PC/address width
- `DATA_WIDTH`, 32, instruction width
- `RESET_PC`, 32'h0000_0000, PC after reset
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `icache_req`  out  1  fetch request valid
- `icache_addr`  out  ADDRESS_WIDTH  fetch address (= PCF)
- `icache_valid`  in  1  instruction returned for `icache_addr` this cycle (same cycle on hit)
- `icache_rdata`  in  DATA_WIDTH  returned instruction
- `StallD`  in  1  hazard unit: hold IF/ID and PCF
- `FlushD`  in  1  hazard unit: bubble IF/ID
- `PCSrcE`  in  1  taken branch / jal / jalr resolved in Execute
- `PCTargetE`  in  ADDRESS_WIDTH  redirect target (PCE+ImmExtE or ALU result)
- `InstrD`  out  DATA_WIDTH  decoded-stage instruction
- `PCD`, `PCPlus4D`  out  ADDRESS_WIDTH  PC and PC+4 of `InstrD`
- `ValidD`  out  1  IF/ID holds a real instruction
- `FetchStall`  out  1  miss outstanding; hazard unit stalls F/D

## Operation
- FSM states: F_RUN, F_WAIT (miss outstanding), F_DRAIN (miss outstanding, redirect pending, response to be discarded).
- F_RUN: `icache_req`=1, `icache_addr`=PCF. If `icache_valid` and !StallD: IF/ID <= {rdata, PCF, PCF+4}, ValidD<=1, PCF<=PCF+4. If !`icache_valid`: go F_WAIT.
- F_WAIT: `icache_req` and `icache_addr` held constant until `icache_valid`; `FetchStall`=1. On `icache_valid`: load as in F_RUN, return to F_RUN.
- Redirect priority: PCSrcE overrides PC+4. In F_RUN: PCF<=PCTargetE; any same-cycle response is not loaded (ValidD<=0). In F_WAIT: latch target, go F_DRAIN; on `icache_valid` discard data, PCF<=latched target, go F_RUN. PCSrcE in F_DRAIN overwrites latched target.
- FlushD: ValidD<=0, InstrD<=32'h0000_0013 (NOP); takes priority over load and over StallD.
- StallD in F_RUN with hit: PCF and IF/ID hold; response handled per Configuration.
- PC arithmetic modulo 2^ADDRESS_WIDTH; PCF=32'hFFFF_FFFC wraps to 0. PCTargetE[1:0] ignored (forced to 00).
- Reset at any time, including mid-miss: state F_RUN, any pending response ignored.

## Timing
- Reset values: PCF=RESET_PC, state F_RUN, InstrD=32'h13, PCD=PCPlus4D=0, ValidD=0, FetchStall=0, hold buffer empty; `icache_req`=1 from first cycle after reset.
- Hit: instruction visible on InstrD one cycle after address presented.
- Miss of N cycles: InstrD updates the cycle after `icache_valid`; FetchStall high for the N-1 cycles before response is accepted.
- Redirect: target on `icache_addr` the cycle after PCSrcE (F_RUN), or the cycle after `icache_valid` (F_DRAIN).
- FetchStall combinational from state (high in F_WAIT/F_DRAIN) only; no combinational path from `icache_valid` to FetchStall.

## Configuration
- `FETCH_HOLD_BUF_EN` defined: one-entry buffer captures a response arriving while StallD=1 (with PC); on StallD release buffer loads IF/ID with no new request issued that cycle; buffer cleared by PCSrcE, FlushD, rst.
- Undefined: response under StallD dropped; same PCF re-requested each cycle until StallD=0.

## Structure
- `cpu_pkg`: `fetch_state_t` enum (F_RUN, F_WAIT, F_DRAIN), `NOP_INSTR`=32'h0000_0013, `RESET_PC` default.
- One sub-module `if_id_reg`: IF/ID register with load, stall, flush, valid; FSM and PC logic stay in `fetch_stage`.

## Test plan
- Reset, hits every cycle -> addresses 0,4,8,12; InstrD follows one cycle later; ValidD=1 from cycle 2.
- Miss at 0x10, `icache_valid` after 5 cycles -> addr held 0x10 for 5 cycles, FetchStall=1 for 4, InstrD=rdata, PCD=0x10, then addr 0x14.
- PCSrcE=1, PCTargetE=0x100 mid-miss at 0x20 -> response for 0x20 discarded, next addr 0x100, ValidD stays 0 for 0x20.
- PCSrcE and FlushD same cycle in F_RUN with hit -> next addr=target, InstrD=0x13, ValidD=0.
- StallD 3 cycles during hits -> PCF and IF/ID frozen; with FETCH_HOLD_BUF_EN one request issued, without it same addr re-requested 3 times; no instruction lost or duplicated.
- PCTargetE=0xFFFF_FFFC then hit -> next addr 0x0; rst asserted mid-miss -> addr RESET_PC next cycle, ValidD=0.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared types and constants for the RV32I core front end.
//               Provides the fetch FSM state type, the canonical NOP
//               encoding (addi x0,x0,0) and the default reset PC.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    typedef enum logic [1:0] {
        F_RUN   = 2'd0,  // issuing a request every cycle
        F_WAIT  = 2'd1,  // miss outstanding, response will be used
        F_DRAIN = 2'd2   // miss outstanding, redirect pending, response discarded
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_reg
// Description : IF/ID pipeline register. Priority: rst > flush > stall >
//               load. When neither stalled nor loaded, the register turns
//               into a bubble (valid cleared) so a held instruction is never
//               presented to Decode twice.
// Ports       : clk, rst           - clock, synchronous active-high reset
//               load               - capture instr_in/pc_in/pc_plus4_in
//               stall              - hold all contents
//               flush              - valid<=0, instr<=NOP
//               instr/pc/pc_plus4  - registered outputs
//               valid              - register holds a real instruction
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_reg
    import cpu_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic                     stall,
    input  logic                     flush,
    input  logic [DATA_WIDTH-1:0]    instr_in,
    input  logic [ADDRESS_WIDTH-1:0] pc_in,
    input  logic [ADDRESS_WIDTH-1:0] pc_plus4_in,
    output logic [DATA_WIDTH-1:0]    instr,
    output logic [ADDRESS_WIDTH-1:0] pc,
    output logic [ADDRESS_WIDTH-1:0] pc_plus4,
    output logic                     valid
);

    always_ff @(posedge clk) begin
        if (rst) begin
            instr    <= DATA_WIDTH'(NOP_INSTR);
            pc       <= '0;
            pc_plus4 <= '0;
            valid    <= 1'b0;
        end else if (flush) begin
            instr    <= DATA_WIDTH'(NOP_INSTR);
            valid    <= 1'b0;
        end else if (stall) begin
            // hold everything
        end else if (load) begin
            instr    <= instr_in;
            pc       <= pc_in;
            pc_plus4 <= pc_plus4_in;
            valid    <= 1'b1;
        end else begin
            valid    <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : RV32I instruction-fetch stage. Holds PCF, requests the
//               instruction cache, rides out miss latency (F_WAIT), applies
//               Execute redirects (discarding an in-flight miss via F_DRAIN)
//               and drives the IF/ID register.
// Macro       : FETCH_HOLD_BUF_EN - when defined, a one-entry buffer keeps a
//               response that arrives under StallD and hands it to IF/ID on
//               release; otherwise such a response is dropped and the same
//               PCF is re-requested.
// Ports       : clk, rst                  - clock, sync active-high reset
//               icache_req/addr           - fetch request, address = PCF
//               icache_valid/rdata        - cache response
//               StallD, FlushD            - hazard-unit controls
//               PCSrcE, PCTargetE         - redirect from Execute
//               InstrD, PCD, PCPlus4D     - IF/ID contents
//               ValidD                    - IF/ID holds a real instruction
//               FetchStall                - miss outstanding
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = ADDRESS_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     icache_req,
    output logic [ADDRESS_WIDTH-1:0] icache_addr,
    input  logic                     icache_valid,
    input  logic [DATA_WIDTH-1:0]    icache_rdata,
    input  logic                     StallD,
    input  logic                     FlushD,
    input  logic                     PCSrcE,
    input  logic [ADDRESS_WIDTH-1:0] PCTargetE,
    output logic [DATA_WIDTH-1:0]    InstrD,
    output logic [ADDRESS_WIDTH-1:0] PCD,
    output logic [ADDRESS_WIDTH-1:0] PCPlus4D,
    output logic                     ValidD,
    output logic                     FetchStall
);

    localparam logic [ADDRESS_WIDTH-1:0] PC_STEP    = ADDRESS_WIDTH'(4);
    localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK = ~ADDRESS_WIDTH'(3);

    fetch_state_t             state, state_nx;
    logic [ADDRESS_WIDTH-1:0] pcf, pcf_nx;
    logic [ADDRESS_WIDTH-1:0] target_q, target_nx;
    logic [ADDRESS_WIDTH-1:0] redirect_pc;
    logic                     resp;
    logic                     take;
    logic                     load;
    logic [DATA_WIDTH-1:0]    load_instr;
    logic [ADDRESS_WIDTH-1:0] load_pc;
    logic [ADDRESS_WIDTH-1:0] load_pc_plus4;

`ifdef FETCH_HOLD_BUF_EN
    logic                     buf_full;
    logic                     buf_set;
    logic                     buf_clr;
    logic [DATA_WIDTH-1:0]    buf_instr;
    logic [ADDRESS_WIDTH-1:0] buf_pc;

    // While the buffer owns an instruction nothing new is requested; this
    // also covers the release cycle when the buffer drains into IF/ID.
    assign icache_req = !buf_full;
`else
    assign icache_req = 1'b1;
`endif

    assign icache_addr   = pcf;
    assign resp          = icache_req & icache_valid;
    assign redirect_pc   = PCTargetE & ALIGN_MASK;
    assign FetchStall    = (state != F_RUN);
    assign load_pc_plus4 = load_pc + PC_STEP;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= F_RUN;
            pcf      <= RESET_PC;
            target_q <= RESET_PC;
        end else begin
            state    <= state_nx;
            pcf      <= pcf_nx;
            target_q <= target_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        pcf_nx     = pcf;
        target_nx  = target_q;
        take       = 1'b0;
        load       = 1'b0;
        load_instr = icache_rdata;
        load_pc    = pcf;
`ifdef FETCH_HOLD_BUF_EN
        buf_set    = 1'b0;
        buf_clr    = 1'b0;
`endif

        unique case (state)
            F_RUN: begin
`ifdef FETCH_HOLD_BUF_EN
                if (buf_full) begin
                    if (PCSrcE) begin
                        pcf_nx  = redirect_pc;
                        buf_clr = 1'b1;
                    end else if (FlushD) begin
                        // PCF was never advanced, so the entry is refetched
                        buf_clr = 1'b1;
                    end else if (!StallD) begin
                        load       = 1'b1;
                        load_instr = buf_instr;
                        load_pc    = buf_pc;
                        pcf_nx     = buf_pc + PC_STEP;
                        buf_clr    = 1'b1;
                    end
                end else
`endif
                if (PCSrcE) begin
                    if (resp) begin
                        pcf_nx = redirect_pc;
                    end else begin
                        // a miss just started on the old PC: keep the
                        // address stable and throw its response away
                        target_nx = redirect_pc;
                        state_nx  = F_DRAIN;
                    end
                end else if (resp) begin
                    take = 1'b1;
                end else begin
                    state_nx = F_WAIT;
                end
            end

            F_WAIT: begin
                if (PCSrcE) begin
                    if (resp) begin
                        pcf_nx   = redirect_pc;
                        state_nx = F_RUN;
                    end else begin
                        target_nx = redirect_pc;
                        state_nx  = F_DRAIN;
                    end
                end else if (resp) begin
                    take     = 1'b1;
                    state_nx = F_RUN;
                end
            end

            F_DRAIN: begin
                if (resp) begin
                    pcf_nx   = PCSrcE ? redirect_pc : target_q;
                    state_nx = F_RUN;
                end else if (PCSrcE) begin
                    target_nx = redirect_pc;
                end
            end

            default: state_nx = F_RUN;
        endcase

        // A usable response for PCF. A flush kills it without advancing PCF
        // so the instruction is fetched again rather than lost.
        if (take && !FlushD) begin
            if (!StallD) begin
                load   = 1'b1;
                pcf_nx = pcf + PC_STEP;
            end
`ifdef FETCH_HOLD_BUF_EN
            else begin
                buf_set = 1'b1;
            end
`endif
        end
    end

`ifdef FETCH_HOLD_BUF_EN
    always_ff @(posedge clk) begin
        if (rst || buf_clr) begin
            buf_full  <= 1'b0;
            buf_instr <= DATA_WIDTH'(NOP_INSTR);
            buf_pc    <= '0;
        end else if (buf_set) begin
            buf_full  <= 1'b1;
            buf_instr <= icache_rdata;
            buf_pc    <= pcf;
        end
    end
`endif

    if_id_reg #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH)
    ) u_if_id_reg (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .stall       (StallD),
        .flush       (FlushD),
        .instr_in    (load_instr),
        .pc_in       (load_pc),
        .pc_plus4_in (load_pc_plus4),
        .instr       (InstrD),
        .pc          (PCD),
        .pc_plus4    (PCPlus4D),
        .valid       (ValidD)
    );

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench for fetch_stage. A behavioural cache
//               answers requests (hit or N-cycle miss) from a hashed memory.
//               The reference model is the architectural instruction stream:
//               every instruction entering Decode must be the next PC in
//               program order (PC+4, or the aligned redirect target), with
//               the memory word for that PC. Directed steps pin down exact
//               cycle timing, then a randomized phase exercises the rest.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam int          AW     = 32;
    localparam int          DW     = 32;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;
`ifdef FETCH_HOLD_BUF_EN
    localparam int EXP_STALL_REQS = 1;
`else
    localparam int EXP_STALL_REQS = 4;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          icache_req;
    logic [AW-1:0] icache_addr;
    logic          icache_valid;
    logic [DW-1:0] icache_rdata;
    logic          StallD;
    logic          FlushD;
    logic          PCSrcE;
    logic [AW-1:0] PCTargetE;
    logic [DW-1:0] InstrD;
    logic [AW-1:0] PCD;
    logic [AW-1:0] PCPlus4D;
    logic          ValidD;
    logic          FetchStall;

    always #5 clk = ~clk;

    fetch_stage #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .RESET_PC      (RST_PC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .icache_req   (icache_req),
        .icache_addr  (icache_addr),
        .icache_valid (icache_valid),
        .icache_rdata (icache_rdata),
        .StallD       (StallD),
        .FlushD       (FlushD),
        .PCSrcE       (PCSrcE),
        .PCTargetE    (PCTargetE),
        .InstrD       (InstrD),
        .PCD          (PCD),
        .PCPlus4D     (PCPlus4D),
        .ValidD       (ValidD),
        .FetchStall   (FetchStall)
    );

    int          total = 0;
    int          bad   = 0;
    // cache model
    bit          c_busy   = 1'b0;
    logic [31:0] c_addr   = '0;
    int          c_cnt    = 0;
    int          next_lat = 1;
    // architectural stream model
    logic [31:0] exp_pc   = RST_PC;
    int          ndeliv   = 0;

    // bijective hash: every address has a distinct instruction word
    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: answer the current request, advance, update models.
    task automatic step();
        logic        r_rst, r_stall, r_flush, r_pcsrc;
        logic [31:0] r_tgt;
        bit          delivered;
        icache_valid = 1'b0;
        icache_rdata = 32'hDEAD_BEEF;
        if (!rst) begin
            chk("fetch_stall", 32'(FetchStall), 32'(c_busy));
            if (c_busy) begin
                chk("miss_hold_req", 32'(icache_req), 1);
                chk("miss_hold_addr", icache_addr, c_addr);
                c_cnt--;
                if (c_cnt == 0) begin
                    icache_valid = 1'b1;
                    icache_rdata = mem(c_addr);
                    c_busy       = 1'b0;
                end
            end else if (icache_req === 1'b1) begin
                if (next_lat <= 1) begin
                    icache_valid = 1'b1;
                    icache_rdata = mem(icache_addr);
                end else begin
                    c_busy = 1'b1;
                    c_addr = icache_addr;
                    c_cnt  = next_lat - 1;
                end
                next_lat = 1;
            end
        end
        r_rst   = rst;
        r_stall = StallD;
        r_flush = FlushD;
        r_pcsrc = PCSrcE;
        r_tgt   = PCTargetE;
        @(posedge clk);
        #1;
        if (r_rst) begin
            c_busy = 1'b0;
            exp_pc = RST_PC;
        end else begin
            delivered = (ValidD === 1'b1) && !r_stall && !r_flush;
            if (r_flush) begin
                chk("flush_valid", 32'(ValidD), 0);
                chk("flush_nop", InstrD, NOP);
            end
            if (r_pcsrc) begin
                chk("redirect_no_load", 32'(delivered), 0);
                exp_pc = r_tgt & ~32'h3;
            end else if (delivered) begin
                chk("stream_pc", PCD, exp_pc);
                chk("stream_instr", InstrD, mem(exp_pc));
                chk("stream_pc4", PCPlus4D, exp_pc + 32'd4);
                exp_pc = exp_pc + 32'd4;
                ndeliv++;
            end
        end
    endtask

    initial begin
        int fs_cnt;
        int reqs;
        rst = 1'b1; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0; PCTargetE = '0;
        icache_valid = 1'b0; icache_rdata = '0;

        // reset values
        step();
        step();
        rst = 1'b0;
        chk("rst_addr", icache_addr, RST_PC);
        chk("rst_req", 32'(icache_req), 1);
        chk("rst_valid", 32'(ValidD), 0);
        chk("rst_instr", InstrD, NOP);
        chk("rst_pcd", PCD, 0);
        chk("rst_pc4d", PCPlus4D, 0);
        chk("rst_fstall", 32'(FetchStall), 0);

        // back-to-back hits
        for (int i = 0; i < 4; i++) begin
            chk("hit_addr", icache_addr, 32'(i * 4));
            step();
            chk("hit_valid", 32'(ValidD), 1);
            chk("hit_pcd", PCD, 32'(i * 4));
            chk("hit_instr", InstrD, mem(32'(i * 4)));
        end

        // 5-cycle miss at 0x10
        next_lat = 5;
        fs_cnt   = 0;
        for (int k = 0; k < 5; k++) begin
            chk("miss_addr", icache_addr, 32'h10);
            if (FetchStall) fs_cnt++;
            step();
        end
        chk("miss_fstall_cycles", 32'(fs_cnt), 4);
        chk("miss_instr", InstrD, mem(32'h10));
        chk("miss_pcd", PCD, 32'h10);
        chk("miss_valid", 32'(ValidD), 1);
        chk("miss_next_addr", icache_addr, 32'h14);

        // redirect in the middle of a 6-cycle miss at 0x20
        step(); step(); step();
        chk("pre_drain_addr", icache_addr, 32'h20);
        next_lat = 6;
        step();
        step();
        PCSrcE = 1'b1; PCTargetE = 32'h100;
        step();
        PCSrcE = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("drain_addr", icache_addr, 32'h20);
            step();
            chk("drain_valid", 32'(ValidD), 0);
        end
        chk("drain_target_addr", icache_addr, 32'h100);
        step();
        chk("drain_pcd", PCD, 32'h100);
        chk("drain_after_valid", 32'(ValidD), 1);

        // redirect plus flush on a hit
        PCSrcE = 1'b1; FlushD = 1'b1; PCTargetE = 32'h200;
        step();
        PCSrcE = 1'b0; FlushD = 1'b0;
        chk("rf_addr", icache_addr, 32'h200);
        chk("rf_instr", InstrD, NOP);
        chk("rf_valid", 32'(ValidD), 0);
        step();

        // StallD for 3 cycles during hits
        reqs   = 0;
        StallD = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("stall_addr", icache_addr, 32'h204);
            reqs += int'(icache_req);
            step();
            chk("stall_pcd", PCD, 32'h200);
            chk("stall_instr", InstrD, mem(32'h200));
        end
        StallD = 1'b0;
        reqs += int'(icache_req);
        step();
        chk("stall_reqs", 32'(reqs), 32'(EXP_STALL_REQS));
        chk("release_pcd", PCD, 32'h204);
        chk("release_instr", InstrD, mem(32'h204));
        chk("release_valid", 32'(ValidD), 1);
        chk("release_addr", icache_addr, 32'h208);

        // misaligned target near the top of memory, then wrap
        PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFF;
        step();
        PCSrcE = 1'b0;
        chk("wrap_target", icache_addr, 32'hFFFF_FFFC);
        step();
        chk("wrap_addr", icache_addr, 32'h0);
        chk("wrap_pcd", PCD, 32'hFFFF_FFFC);
        chk("wrap_pc4", PCPlus4D, 32'h0);

        // reset in the middle of a miss at 0x4
        step();
        next_lat = 8;
        step();
        step();
        chk("mid_miss_fstall", 32'(FetchStall), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_addr", icache_addr, RST_PC);
        chk("mid_rst_valid", 32'(ValidD), 0);
        chk("mid_rst_fstall", 32'(FetchStall), 0);

        // randomized traffic against the stream model
        ndeliv = 0;
        for (int n = 0; n < 500; n++) begin
            rst       = ($urandom_range(99) == 0);
            StallD    = ($urandom_range(99) < 20);
            FlushD    = ($urandom_range(99) < 5);
            PCSrcE    = ($urandom_range(99) < 8);
            PCTargetE = $urandom;
            next_lat  = ($urandom_range(99) < 60) ? 1 : int'($urandom_range(6, 2));
            step();
        end
        rst = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
        for (int n = 0; n < 10; n++) step();
        chk("progress", 32'(ndeliv >= 40), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
